register_file_sb: RTL and testbench

Parametrised 2-read/1-write register file for the pipelined successor of the 16-bit processor.
- Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending-write scoreboard with an issue handshake and flush.
- Sits between decode/issue (reads, destination reservation) and writeback (data return).
- The decode stage uses the Busy outputs to stall on RAW hazards and IssueReady to stall on WAW hazards.

---
 rtl/register_file_sb.sv | 124 ++++++++++++
 tb/tb_register_file_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - 2R/1W register file with write bypass, zero register and pending-write scoreboard
module register_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         RegRead1,
  input  logic [ADDR_W-1:0]         RegRead2,
  output logic [DATA_W-1:0]         ReadData1,
  output logic [DATA_W-1:0]         ReadData2,
  output logic                      Busy1,
  output logic                      Busy2,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         WriteReg,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic                      IssueValid,
  input  logic [ADDR_W-1:0]         IssueReg,
  output logic                      IssueReady,
  input  logic                      Flush,
  output logic [(2**ADDR_W)-1:0]    PendingMask
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  // Register storage and scoreboard state
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  // Decoded control
  logic              w_wr_en;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_zero1;
  logic              w_zero2;
  logic              w_issue_ready;
  logic              w_issue_take;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_busy1;
  logic              w_busy2;

  // A write to the hardwired zero register is dropped entirely
  assign w_wr_en = RegWrite && !(ZERO_EN && (WriteReg == '0));

  // Same-cycle write matches on each read port (only meaningful when bypass is enabled)
  assign w_hit1  = BYPASS_EN && RegWrite && (WriteReg == RegRead1);
  assign w_hit2  = BYPASS_EN && RegWrite && (WriteReg == RegRead2);
  assign w_zero1 = ZERO_EN && (RegRead1 == '0);
  assign w_zero2 = ZERO_EN && (RegRead2 == '0);

  // A destination can be reserved if it is free, is being freed by the retiring write,
  // or is the zero register; nothing can be reserved while a flush is in progress
  assign w_issue_ready = !Flush &&
                         (!r_pend[IssueReg] ||
                          (RegWrite && (WriteReg == IssueReg)) ||
                          (ZERO_EN && (IssueReg == '0)));

  // Reserving the zero register is accepted but leaves no trace in the scoreboard
  assign w_issue_take  = IssueValid && w_issue_ready && !(ZERO_EN && (IssueReg == '0));

  // Read port 1: zero register beats bypass, bypass beats stored value
  always_comb begin
    w_rd1 = r_regs[RegRead1];
    if (w_hit1)  w_rd1 = WriteData;
    if (w_zero1) w_rd1 = '0;
  end

  // Read port 2: same override order as port 1
  always_comb begin
    w_rd2 = r_regs[RegRead2];
    if (w_hit2)  w_rd2 = WriteData;
    if (w_zero2) w_rd2 = '0;
  end

  // Busy: pending bit, masked by a retiring forwarded write or the zero register
  always_comb begin
    w_busy1 = r_pend[RegRead1];
    w_busy2 = r_pend[RegRead2];
    if (w_hit1 || w_zero1) w_busy1 = 1'b0;
    if (w_hit2 || w_zero2) w_busy2 = 1'b0;
  end

  // Next scoreboard: write clears, then an accepted issue sets (issue wins), flush clears all
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en)      w_pend_nxt[WriteReg] = 1'b0;
    if (w_issue_take) w_pend_nxt[IssueReg] = 1'b1;
    if (Flush)        w_pend_nxt = '0;
  end

  // Register data update; flush does not touch data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[WriteReg] <= WriteData;
    end
  end

  // Scoreboard update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign ReadData1   = w_rd1;
  assign ReadData2   = w_rd2;
  assign Busy1       = w_busy1;
  assign Busy2       = w_busy2;
  assign IssueReady  = w_issue_ready;
  assign PendingMask = r_pend;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - randomized model-checked bench for register_file_sb (two configurations)
module tb_register_file_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus; instance A uses the low address/data bits
  logic [4:0]  s_rr1 = '0, s_rr2 = '0, s_wa = '0, s_ia = '0;
  logic [31:0] s_wd = '0;
  logic        s_we = 1'b0, s_iv = 1'b0, s_fl = 1'b0;

  logic [15:0] a_rd1, a_rd2, a_pm;
  logic        a_b1, a_b2, a_ir;
  logic [31:0] b_rd1, b_rd2, b_pm;
  logic        b_b1, b_b2, b_ir;

  register_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .reset(rst_n),
    .RegRead1(s_rr1[3:0]), .RegRead2(s_rr2[3:0]),
    .ReadData1(a_rd1), .ReadData2(a_rd2), .Busy1(a_b1), .Busy2(a_b2),
    .RegWrite(s_we), .WriteReg(s_wa[3:0]), .WriteData(s_wd[15:0]),
    .IssueValid(s_iv), .IssueReg(s_ia[3:0]), .IssueReady(a_ir),
    .Flush(s_fl), .PendingMask(a_pm)
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(rst_n),
    .RegRead1(s_rr1), .RegRead2(s_rr2),
    .ReadData1(b_rd1), .ReadData2(b_rd2), .Busy1(b_b1), .Busy2(b_b2),
    .RegWrite(s_we), .WriteReg(s_wa), .WriteData(s_wd),
    .IssueValid(s_iv), .IssueReg(s_ia), .IssueReady(b_ir),
    .Flush(s_fl), .PendingMask(b_pm)
  );

  // Behavioural model: index 0 = instance A, 1 = instance B
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];
  int          cfg_depth [2] = '{16, 32};
  bit          cfg_zero  [2] = '{1'b1, 1'b0};
  bit          cfg_byp   [2] = '{1'b1, 1'b0};
  logic [31:0] cfg_dmask [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] madr(input int k, input logic [4:0] a);
    return (k == 0) ? {1'b0, a[3:0]} : a;
  endfunction

  function automatic logic [31:0] m_rd(input int k, input logic [4:0] a_in);
    logic [4:0] a = madr(k, a_in);
    if (cfg_zero[k] && a == 0) return 32'h0;
    if (cfg_byp[k] && s_we && madr(k, s_wa) == a) return s_wd & cfg_dmask[k];
    return m_regs[k][a];
  endfunction

  function automatic logic m_busy(input int k, input logic [4:0] a_in);
    logic [4:0] a = madr(k, a_in);
    if (cfg_zero[k] && a == 0) return 1'b0;
    if (cfg_byp[k] && s_we && madr(k, s_wa) == a) return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic logic m_irdy(input int k);
    logic [4:0] ia = madr(k, s_ia);
    if (s_fl) return 1'b0;
    return !m_pend[k][ia] || (s_we && madr(k, s_wa) == ia) || (cfg_zero[k] && ia == 0);
  endfunction

  function automatic logic [31:0] m_pm(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < cfg_depth[k]; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  // Model state update mirrors the architectural rules at each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] = '0;
          m_pend[k][i] = 1'b0;
        end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [4:0] wa, ia;
        logic rdy;
        wa  = madr(k, s_wa);
        ia  = madr(k, s_ia);
        rdy = m_irdy(k);
        if (s_we && !(cfg_zero[k] && wa == 0)) begin
          m_regs[k][wa] = s_wd & cfg_dmask[k];
          m_pend[k][wa] = 1'b0;
        end
        if (s_fl) begin
          for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
        end else if (s_iv && rdy && !(cfg_zero[k] && ia == 0)) begin
          m_pend[k][ia] = 1'b1;
        end
      end
    end
  end

  // Compare process: all outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A rd1",  {16'h0, a_rd1}, m_rd(0, s_rr1));
      chk("A rd2",  {16'h0, a_rd2}, m_rd(0, s_rr2));
      chk("A busy1", {31'h0, a_b1}, {31'h0, m_busy(0, s_rr1)});
      chk("A busy2", {31'h0, a_b2}, {31'h0, m_busy(0, s_rr2)});
      chk("A irdy",  {31'h0, a_ir}, {31'h0, m_irdy(0)});
      chk("A pmask", {16'h0, a_pm}, m_pm(0));
      chk("B rd1",  b_rd1, m_rd(1, s_rr1));
      chk("B rd2",  b_rd2, m_rd(1, s_rr2));
      chk("B busy1", {31'h0, b_b1}, {31'h0, m_busy(1, s_rr1)});
      chk("B busy2", {31'h0, b_b2}, {31'h0, m_busy(1, s_rr2)});
      chk("B irdy",  {31'h0, b_ir}, {31'h0, m_irdy(1)});
      chk("B pmask", b_pm, m_pm(1));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    s_we = 1'b0; s_iv = 1'b0; s_fl = 1'b0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #10 rst_n = 1'b1;

    // Reset then read
    s_rr1 = 5'd5; s_rr2 = 5'd15;
    at_neg();
    chk("t1 rd1", {16'h0, a_rd1}, 32'h0);
    chk("t1 rd2", {16'h0, a_rd2}, 32'h0);
    chk("t1 busy", {30'h0, a_b1, a_b2}, 32'h0);
    chk("t1 pmask", {16'h0, a_pm}, 32'h0);
    chk("t1 irdy", {31'h0, a_ir}, 32'h1);

    // Write r3, then read it while writing r4 with bypass
    next_cycle(); s_we = 1'b1; s_wa = 5'd3; s_wd = 32'h0000_BEEF;
    next_cycle(); s_rr1 = 5'd3; s_rr2 = 5'd4; s_we = 1'b1; s_wa = 5'd4; s_wd = 32'h0000_1234;
    at_neg();
    chk("t2 A rd1", {16'h0, a_rd1}, 32'h0000_BEEF);
    chk("t2 A bypass", {16'h0, a_rd2}, 32'h0000_1234);
    chk("t2 B rd1", b_rd1, 32'h0000_BEEF);
    chk("t2 B nobypass", b_rd2, 32'h0);

    // Zero register
    next_cycle(); s_we = 1'b1; s_wa = 5'd0; s_wd = 32'h0000_FFFF; s_rr1 = 5'd0;
    at_neg();
    chk("t3 A r0 write", {16'h0, a_rd1}, 32'h0);
    next_cycle(); s_iv = 1'b1; s_ia = 5'd0;
    at_neg();
    chk("t3 A r0 irdy", {31'h0, a_ir}, 32'h1);
    chk("t3 B r0 data", b_rd1, 32'h0000_FFFF);
    next_cycle();
    at_neg();
    chk("t3 A r0 pmask", {16'h0, a_pm}, 32'h0);
    chk("t3 B r0 pmask", b_pm, 32'h1);

    // Scoreboard RAW / WAW
    next_cycle(); s_iv = 1'b1; s_ia = 5'd7;
    next_cycle(); s_rr1 = 5'd7;
    at_neg();
    chk("t4 pmask", {16'h0, a_pm}, 32'h0080);
    chk("t4 busy1", {31'h0, a_b1}, 32'h1);
    next_cycle(); s_iv = 1'b1; s_ia = 5'd7;
    at_neg();
    chk("t4 waw irdy", {31'h0, a_ir}, 32'h0);
    next_cycle(); s_iv = 1'b1; s_ia = 5'd7; s_we = 1'b1; s_wa = 5'd7; s_wd = 32'h0000_00AA;
    at_neg();
    chk("t4 retire busy1", {31'h0, a_b1}, 32'h0);
    chk("t4 retire irdy", {31'h0, a_ir}, 32'h1);
    chk("t4 retire rd1", {16'h0, a_rd1}, 32'h0000_00AA);
    next_cycle();
    at_neg();
    chk("t4 reissue pmask", {16'h0, a_pm}, 32'h0080);

    // Flush
    next_cycle(); s_fl = 1'b1;
    next_cycle(); s_iv = 1'b1; s_ia = 5'd1;
    next_cycle(); s_iv = 1'b1; s_ia = 5'd2;
    next_cycle(); s_iv = 1'b1; s_ia = 5'd9;
    next_cycle();
    at_neg();
    chk("t5 pmask", {16'h0, a_pm}, 32'h0206);
    next_cycle(); s_fl = 1'b1; s_we = 1'b1; s_wa = 5'd5; s_wd = 32'h0000_5555; s_iv = 1'b1; s_ia = 5'd6;
    at_neg();
    chk("t5 flush irdy", {31'h0, a_ir}, 32'h0);
    next_cycle(); s_rr1 = 5'd5;
    at_neg();
    chk("t5 flush pmask", {16'h0, a_pm}, 32'h0);
    chk("t5 flush data", {16'h0, a_rd1}, 32'h0000_5555);

    // Async reset mid-operation
    next_cycle(); s_we = 1'b1; s_wa = 5'd3; s_wd = 32'h0000_BEEF; s_iv = 1'b1; s_ia = 5'd7;
    next_cycle(); s_rr1 = 5'd3; s_rr2 = 5'd7;
    at_neg();
    chk("t6 pre rd1", {16'h0, a_rd1}, 32'h0000_BEEF);
    chk("t6 pre pmask", {16'h0, a_pm}, 32'h0080);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6 async A rd1", {16'h0, a_rd1}, 32'h0);
    chk("t6 async A pmask", {16'h0, a_pm}, 32'h0);
    chk("t6 async B rd1", b_rd1, 32'h0);
    chk("t6 async B pmask", b_pm, 32'h0);
    #1 rst_n = 1'b1;

    // Randomized traffic, biased toward a few registers to create hazards
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      s_rr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_rr2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_ia  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_wd  = $urandom;
      s_we  = ($urandom_range(0, 2) == 0);
      s_iv  = ($urandom_range(0, 1) != 0);
      s_fl  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    next_cycle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
